// File: rtl/bayer_window_feeder.sv
// Raw Bayer raster front end: builds the 3x3 neighbourhood of each interior pixel,
// runs a start/done handshake with the greyscale converter and forwards its result.
module bayer_window_feeder #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_pixel,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [199:0] matriz_a,
    output logic [1:0]   pixel_region,
    output logic         start,
    input  logic         done,
    input  logic [7:0]   result,
    output logic [7:0]   out_pixel,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OUT, S_GAP} state_t;

    state_t         r_state;
    logic [CW-1:0]  r_col;
    logic [RW-1:0]  r_row;
    logic           r_in_ready;
    logic           r_start;
    logic           r_out_valid;
    logic [7:0]     r_out_pixel;
    logic [199:0]   r_matriz_a;
    logic [1:0]     r_pixel_region;
    logic           r_frame_done;
    logic           r_last_win;

    // Line buffers hold rows r-1 and r-2; shift registers hold columns c-1 (idx 0) and c-2 (idx 1).
    logic [7:0]     r_lb1 [IMG_W];
    logic [7:0]     r_lb2 [IMG_W];
    logic [7:0]     r_sr  [3][2];

    logic           w_accept;
    logic           w_interior;
    logic           w_col_last;
    logic           w_row_last;
    logic [7:0]     w_col_px [3];
    logic [199:0]   w_window;

    assign w_accept   = in_valid && r_in_ready;
    assign w_interior = (r_row >= RW'(2)) && (r_col >= CW'(2));
    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));

    // Newest column of the window: rows r-2, r-1 from the line buffers, row r from the input.
    assign w_col_px[0] = r_lb2[r_col];
    assign w_col_px[1] = r_lb1[r_col];
    assign w_col_px[2] = in_pixel;

    always_comb begin
        w_window = '0;
        for (int y = 0; y < 3; y++) begin
            w_window[40*y +: 8]      = r_sr[y][1];
            w_window[40*y + 8 +: 8]  = r_sr[y][0];
            w_window[40*y + 16 +: 8] = w_col_px[y];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_lb2[r_col] <= r_lb1[r_col];
            r_lb1[r_col] <= in_pixel;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_shift
            always_ff @(posedge clk) begin
                if (w_accept) begin
                    r_sr[gi][1] <= r_sr[gi][0];
                    r_sr[gi][0] <= w_col_px[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_col          <= '0;
            r_row          <= '0;
            r_in_ready     <= 1'b0;
            r_start        <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_pixel    <= '0;
            r_matriz_a     <= '0;
            r_pixel_region <= '0;
            r_frame_done   <= 1'b0;
            r_last_win     <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        if (w_col_last) begin
                            r_col <= '0;
                            r_row <= w_row_last ? '0 : r_row + RW'(1);
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                        if (w_interior) begin
                            r_matriz_a     <= w_window;
                            // Centre is (r-1, c-1), so its parity is the inverse of the current sample's.
                            r_pixel_region <= {~r_row[0], ~r_col[0]};
                            r_last_win     <= w_row_last && w_col_last;
                            r_start        <= 1'b1;
                            r_in_ready     <= 1'b0;
                            r_state        <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (done) begin
                        r_out_pixel <= result;
                        r_out_valid <= 1'b1;
                        r_start     <= 1'b0;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        r_out_valid  <= 1'b0;
                        r_frame_done <= r_last_win;
                        r_state      <= S_GAP;
                    end
                end
                S_GAP: begin
                    r_in_ready <= 1'b1;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = r_in_ready;
    assign start        = r_start;
    assign out_valid    = r_out_valid;
    assign out_pixel    = r_out_pixel;
    assign matriz_a     = r_matriz_a;
    assign pixel_region = r_pixel_region;
    assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_bayer_window_feeder.sv
// Scoreboard bench for bayer_window_feeder on a 4x4 frame with a 5-cycle converter model.
module tb_bayer_window_feeder;
    localparam int W = 4;
    localparam int H = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [7:0]   in_pixel;
    logic         in_valid;
    logic         in_ready;
    logic [199:0] matriz_a;
    logic [1:0]   pixel_region;
    logic         start;
    logic         done;
    logic [7:0]   result;
    logic [7:0]   out_pixel;
    logic         out_valid;
    logic         out_ready;
    logic         frame_done;

    bayer_window_feeder #(.IMG_W(W), .IMG_H(H)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .in_pixel     (in_pixel),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .matriz_a     (matriz_a),
        .pixel_region (pixel_region),
        .start        (start),
        .done         (done),
        .result       (result),
        .out_pixel    (out_pixel),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_out   = 0;
    int n_fd    = 0;
    logic stall_req = 1'b0;

    logic [7:0]   img [H][W];
    logic [7:0]   q_grey [$];
    logic [1:0]   q_reg  [$];
    logic [199:0] q_win  [$];

    task automatic chk(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Converter model: demosaic the centre then weight R/G/B by 0x4D/0x96/0x1D.
    function automatic logic [7:0] conv(input logic [71:0] w, input logic [1:0] rg);
        int px [3][3];
        int hs, vs, ds, rr, gg, bb;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                px[y][x] = int'(w[24*y + 8*x +: 8]);
        hs = px[1][0] + px[1][2];
        vs = px[0][1] + px[2][1];
        ds = px[0][0] + px[0][2] + px[2][0] + px[2][2];
        case (rg)
            2'b01:   begin rr = px[1][1]; gg = (hs + vs) / 4; bb = ds / 4; end
            2'b10:   begin bb = px[1][1]; gg = (hs + vs) / 4; rr = ds / 4; end
            2'b00:   begin gg = px[1][1]; rr = hs / 2; bb = vs / 2; end
            default: begin gg = px[1][1]; bb = hs / 2; rr = vs / 2; end
        endcase
        return 8'((77 * rr + 150 * gg + 29 * bb) >> 8);
    endfunction

    function automatic logic [71:0] img_win(input int r, input int c);
        logic [71:0] w = '0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                w[24*y + 8*x +: 8] = img[r-2+y][c-2+x];
        return w;
    endfunction

    function automatic logic [199:0] to_bus(input logic [71:0] w);
        logic [199:0] b = '0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                b[40*y + 8*x +: 8] = w[24*y + 8*x +: 8];
        return b;
    endfunction

    function automatic logic [71:0] from_bus(input logic [199:0] b);
        logic [71:0] w = '0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 3; x++)
                w[24*y + 8*x +: 8] = b[40*y + 8*x +: 8];
        return w;
    endfunction

    // Converter responder: done after 5 cycles of start high.
    initial begin
        int cnt = 0;
        done = 1'b0;
        result = '0;
        forever begin
            @(negedge clk);
            if (start) cnt++;
            else cnt = 0;
            done = start && (cnt >= 5);
            result = done ? conv(from_bus(matriz_a), pixel_region) : 8'($urandom);
        end
    end

    // Monitor: window/region at start rise, grey at each output handshake.
    initial begin
        logic prev_start = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                prev_start = 1'b0;
            end else begin
                if (start && !prev_start) begin
                    if (q_reg.size() == 0) chk("start_without_window", 200'(q_reg.size()), 200'd1);
                    else begin
                        chk("region", 200'(pixel_region), 200'(q_reg.pop_front()));
                        chk("window", matriz_a, q_win.pop_front());
                    end
                end
                prev_start = start;
                if (out_valid && out_ready) begin
                    n_out++;
                    if (q_grey.size() == 0) chk("output_without_sample", 200'(q_grey.size()), 200'd1);
                    else begin
                        chk("grey", 200'(out_pixel), 200'(q_grey[0]));
                        $display("[TB] out #%0d grey=%0d", n_out, out_pixel);
                        void'(q_grey.pop_front());
                    end
                end
                if (frame_done) n_fd++;
            end
        end
    end

    // Backpressure: hold out_ready low for 20 cycles on the first output after stall_req.
    initial begin
        logic [7:0] hold;
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (stall_req && out_valid) begin
                hold = out_pixel;
                out_ready = 1'b0;
                repeat (20) begin
                    @(negedge clk);
                    chk("stall_out_pixel", 200'(out_pixel), 200'(hold));
                    chk("stall_out_valid", 200'(out_valid), 200'd1);
                    chk("stall_in_ready", 200'(in_ready), 200'd0);
                    chk("stall_start", 200'(start), 200'd0);
                end
                out_ready = 1'b1;
                stall_req = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input int r, input int c, input bit gaps);
        int t = 0;
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        in_pixel = img[r][c];
        in_valid = 1'b1;
        while (!in_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("in_ready_timeout", 200'(t), 200'd0);
        if (r >= 2 && c >= 2) begin
            q_grey.push_back(conv(img_win(r, c), {1'(r - 1), 1'(c - 1)}));
            q_reg.push_back({1'(r - 1), 1'(c - 1)});
            q_win.push_back(to_bus(img_win(r, c)));
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic fill(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (mode)
                    0:       img[r][c] = 8'd100;
                    1:       img[r][c] = 8'(16 * r + c);
                    default: img[r][c] = 8'($urandom);
                endcase
    endtask

    task automatic send_frame(input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(r, c, gaps);
    endtask

    task automatic drain();
        int t = 0;
        while ((q_grey.size() != 0 || !in_ready) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 200'(t < 500), 200'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic frame_check(input string tag, input int outs, input int fds);
        drain();
        chk({tag, "_outputs"}, 200'(n_out), 200'(outs));
        chk({tag, "_frame_done"}, 200'(n_fd), 200'(fds));
        n_out = 0;
        n_fd = 0;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        in_pixel = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 200'(in_ready), 200'd0);
        chk("rst_start", 200'(start), 200'd0);
        chk("rst_out_valid", 200'(out_valid), 200'd0);
        chk("rst_out_pixel", 200'(out_pixel), 200'd0);
        chk("rst_matriz_a", matriz_a, 200'd0);
        chk("rst_region", 200'(pixel_region), 200'd0);
        chk("rst_frame_done", 200'(frame_done), 200'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 200'(in_ready), 200'd1);

        fill(0); send_frame(1'b0); frame_check("flat", 4, 1);
        fill(1); send_frame(1'b0); frame_check("ramp", 4, 1);
        fill(2); stall_req = 1'b1; send_frame(1'b0); frame_check("stall", 4, 1);
        chk("stall_consumed", 200'(stall_req), 200'd0);
        fill(2); send_frame(1'b0); frame_check("nogap", 4, 1);
        send_frame(1'b1); frame_check("gaps", 4, 1);

        // Abort mid-transaction, then restart the frame from (0,0).
        fill(1);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                if (r < 2 || c <= 2) send(r, c, 1'b0);
        chk("abort_start_high", 200'(start), 200'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_start", 200'(start), 200'd0);
        chk("abort_out_valid", 200'(out_valid), 200'd0);
        chk("abort_in_ready", 200'(in_ready), 200'd0);
        chk("abort_matriz_a", matriz_a, 200'd0);
        q_grey.delete();
        q_reg.delete();
        q_win.delete();
        n_out = 0;
        n_fd = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fill(2); send_frame(1'b0); frame_check("after_abort", 4, 1);

        fill(2); send_frame(1'b0);
        fill(2); send_frame(1'b0);
        frame_check("two_frames", 8, 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
